key_debounce: RTL and testbench



---
 rtl/key_debounce_if.sv | 16 +
 rtl/key_debounce.sv | 53 +++++
 tb/tb_key_debounce.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key pins in, debounced level and press/release pulses out
// Ports (signals):
//   key_raw     raw active-low button pins, driven by the board side
//   key_level   debounced active-low level, feeds the PIO in_port
//   key_press   one-cycle pulse per accepted press (1->0)
//   key_release one-cycle pulse per accepted release (0->1)
interface key_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] key_raw;
    logic [WIDTH-1:0] key_level;
    logic [WIDTH-1:0] key_press;
    logic [WIDTH-1:0] key_release;
    modport master (output key_raw, input key_level, key_press, key_release);
    modport slave (input key_raw, output key_level, key_press, key_release);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: per-key synchroniser, stability-counter debounce and edge pulses
// Ports:
//   clk    system clock (same as the PIO)
//   reset  synchronous active-high reset
//   bus    key_debounce_if slave: key_raw in; key_level, key_press, key_release out
module key_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input logic           clk,
    input logic           reset,
    key_debounce_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stb;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] r_release;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= '1;
            r_s2      <= '1;
            r_stb     <= '1;
            r_press   <= '0;
            r_release <= '0;
            r_cnt     <= '{default: '0};
        end else begin
            r_s1 <= bus.key_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < WIDTH; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;
                // any return to the stable level discards the partial count
                if (r_s2[i] == r_stb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != LAST) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else begin
                    r_cnt[i]     <= '0;
                    r_stb[i]     <= r_s2[i];
                    r_press[i]   <= ~r_s2[i];
                    r_release[i] <= r_s2[i];
                end
            end
        end
    end
    assign bus.key_level   = r_stb;
    assign bus.key_press   = r_press;
    assign bus.key_release = r_release;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of debounce timing, glitch rejection and reset
module tb_key_debounce;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    key_debounce_if #(.WIDTH(4)) bus ();
    key_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        logic [11:0] exp;
        logic [11:0] got;
        reset = 1'b1;
        bus.key_raw = 4'h0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            got = {bus.key_level, bus.key_press, bus.key_release};
            exp = {4'hF, 4'h0, 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %h expected %h", k, got, exp);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            got = {bus.key_level, bus.key_press, bus.key_release};
            exp = {(k >= 6) ? 4'h0 : 4'hF, (k == 6) ? 4'hF : 4'h0, 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_held_press edge%0d: got %h expected %h", k, got, exp);
            end
        end
        bus.key_raw = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            got = {bus.key_level, bus.key_press, bus.key_release};
            exp = {(k >= 6) ? 4'hF : 4'h0, 4'h0, (k == 6) ? 4'hF : 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_release edge%0d: got %h expected %h", k, got, exp);
            end
        end
    endtask
    task automatic test_press_release();
        logic [11:0] exp;
        logic [11:0] got;
        bus.key_raw = 4'hE;
        for (int k = 1; k <= 7; k++) begin
            tick();
            got = {bus.key_level, bus.key_press, bus.key_release};
            exp = {(k >= 6) ? 4'hE : 4'hF, (k == 6) ? 4'h1 : 4'h0, 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clean_press edge%0d: got %h expected %h", k, got, exp);
            end
        end
        bus.key_raw = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            got = {bus.key_level, bus.key_press, bus.key_release};
            exp = {(k >= 6) ? 4'hF : 4'hE, 4'h0, (k == 6) ? 4'h1 : 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clean_release edge%0d: got %h expected %h", k, got, exp);
            end
        end
    endtask
    task automatic test_bounce();
        logic [11:0] got;
        for (int b = 0; b < 4; b++) begin
            bus.key_raw = b[0] ? 4'hF : 4'hD;
            for (int k = 0; k < 2; k++) begin
                tick();
                got = {bus.key_level, bus.key_press, bus.key_release};
                n_checks++;
                if (got !== 12'hF00) begin
                    n_fail++;
                    $display("FAIL bounce_toggle b%0d: got %h expected f00", b, got);
                end
            end
        end
        bus.key_raw = 4'hD;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (bus.key_press !== ((k == 6) ? 4'h2 : 4'h0)) begin
                n_fail++;
                $display("FAIL bounce_settle edge%0d: press %h expected %h", k, bus.key_press,
                         (k == 6) ? 4'h2 : 4'h0);
            end
        end
        bus.key_raw = 4'hF;
        repeat (8) tick();
    endtask
    task automatic test_glitch();
        logic [11:0] got;
        bus.key_raw = 4'hB;
        repeat (3) tick();
        bus.key_raw = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            got = {bus.key_level, bus.key_press, bus.key_release};
            n_checks++;
            if (got !== 12'hF00) begin
                n_fail++;
                $display("FAIL glitch edge%0d: got %h expected f00", k, got);
            end
        end
        n_checks++;
        if (dut.r_cnt[2] !== 3'd0) begin
            n_fail++;
            $display("FAIL glitch_cnt: got %0d expected 0", dut.r_cnt[2]);
        end
    endtask
    task automatic test_simultaneous();
        logic [11:0] exp;
        logic [11:0] got;
        bus.key_raw = 4'h6;
        for (int k = 1; k <= 7; k++) begin
            tick();
            got = {bus.key_level, bus.key_press, bus.key_release};
            exp = {(k >= 6) ? 4'h6 : 4'hF, (k == 6) ? 4'h9 : 4'h0, 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL simultaneous edge%0d: got %h expected %h", k, got, exp);
            end
        end
        bus.key_raw = 4'hF;
        repeat (8) tick();
    endtask
    task automatic test_reset_mid_count();
        logic [11:0] exp;
        logic [11:0] got;
        bus.key_raw = 4'hE;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (bus.key_press !== 4'h0) begin
                n_fail++;
                $display("FAIL midcount_pre cyc%0d: press %h expected 0", k, bus.key_press);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            got = {bus.key_level, bus.key_press, bus.key_release};
            exp = {(k >= 6) ? 4'hE : 4'hF, (k == 6) ? 4'h1 : 4'h0, 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL midcount_post edge%0d: got %h expected %h", k, got, exp);
            end
        end
    endtask
    initial begin
        bus.key_raw = 4'hF;
        test_reset();
        test_press_release();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
